vga_vertex_feeder: RTL

Transmitting end of the vertex interface consumed by the VGA display block. It sits on the Memory Manager side, buffers a display list of FP16 (IEEE-754 half) X/Y vertex pairs written by upstream logic, and replays the whole list to the VGA block once per frame. Each replay is a burst: `oEnable` is held high and `oVertex` strobes once per vertex while `o_ieee754X`/`o_ieee754Y` are stable.

---
 rtl/vga_vertex_feeder_if.sv | 29 ++
 rtl/vga_vertex_feeder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_vertex_feeder_if.sv
// Vertex feeder bus: upstream display-list writes, control strobes, and the
// vertex burst outputs that drive the VGA display block.
interface vga_vertex_feeder_if;
  logic        iWrValid;
  logic [15:0] iWrX;
  logic [15:0] iWrY;
  logic        oWrReady;
  logic        iCommit;
  logic        iClear;
  logic        iVGAVerticalSync;
  logic        oEnable;
  logic        oVertex;
  logic [15:0] o_ieee754X;
  logic [15:0] o_ieee754Y;
  logic        oBusy;
  logic        oOverflow;

  // Feeder side: consumes writes/control, produces the vertex burst.
  modport slave (
    input  iWrValid, iWrX, iWrY, iCommit, iClear, iVGAVerticalSync,
    output oWrReady, oEnable, oVertex, o_ieee754X, o_ieee754Y, oBusy, oOverflow
  );

  // Upstream/controller side.
  modport master (
    output iWrValid, iWrX, iWrY, iCommit, iClear, iVGAVerticalSync,
    input  oWrReady, oEnable, oVertex, o_ieee754X, o_ieee754Y, oBusy, oOverflow
  );
endinterface

// File: rtl/vga_vertex_feeder.sv
// vga_vertex_feeder: buffers a display list of FP16 {X,Y} vertex pairs and
// replays the whole list to the VGA block as one burst per frame.
// Optional feature macro: VGA_FEEDER_VSYNC_EN -- when defined, each burst waits
// for the rising edge of iVGAVerticalSync; otherwise bursts repeat back-to-back
// separated by a single idle cycle.
module vga_vertex_feeder #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 3
) (
  input logic                iClock,
  input logic                iReset,
  vga_vertex_feeder_if.slave bus
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [3:0]      GAP_LAST   = 4'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [AW:0]   count_reg;
  logic [AW-1:0] rd_idx_reg;
  logic [3:0]    gap_reg;
  logic          overflow_reg;
  logic [31:0]   out_reg;
  logic [31:0]   mem [DEPTH];

  logic          wr_fire;
  logic          frame_start;
  logic          enter_send;
  logic          last_vertex;
  logic [AW-1:0] send_idx;

  // A write lands only while loading and only if there is room.
  assign wr_fire = (state_reg == ST_LOAD) && bus.iWrValid && (count_reg < FULL_COUNT);

  // The current index is the final vertex of the list.
  assign last_vertex = ({1'b0, rd_idx_reg} + (AW+1)'(1)) >= count_reg;

`ifdef VGA_FEEDER_VSYNC_EN
  logic vs_cur_reg;
  logic vs_prev_reg;

  // Register vsync once and keep the previous sample for edge detection;
  // both start high so the idle level never looks like an edge.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      vs_cur_reg  <= 1'b1;
      vs_prev_reg <= 1'b1;
    end else begin
      vs_cur_reg  <= bus.iVGAVerticalSync;
      vs_prev_reg <= vs_cur_reg;
    end
  end

  // Frame start is the end of the active-low sync pulse.
  assign frame_start = vs_cur_reg & ~vs_prev_reg;
`else
  logic vsync_unused;
  assign vsync_unused = bus.iVGAVerticalSync;

  // Free-running: ARM always proceeds after a single cycle.
  assign frame_start = 1'b1;
`endif

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_next = state_reg;
    enter_send = 1'b0;
    send_idx   = rd_idx_reg;
    case (state_reg)
      ST_LOAD: begin
        if (bus.iCommit && ((count_reg != '0) || wr_fire)) begin
          state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        if (frame_start) begin
          state_next = ST_SEND;
          enter_send = 1'b1;
          send_idx   = '0;
        end
      end
      ST_SEND: begin
        state_next = ST_GAP;
      end
      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          if (last_vertex) begin
            state_next = ST_ARM;
          end else begin
            state_next = ST_SEND;
            enter_send = 1'b1;
            send_idx   = rd_idx_reg + AW'(1);
          end
        end
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
    if (bus.iClear) begin
      state_next = ST_LOAD;
      enter_send = 1'b0;
    end
  end

  // Control state: FSM, list length, replay index, gap timer, sticky overflow.
  always_ff @(posedge iClock) begin
    if (iReset || bus.iClear) begin
      state_reg    <= ST_LOAD;
      count_reg    <= '0;
      rd_idx_reg   <= '0;
      gap_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (wr_fire) begin
        count_reg <= count_reg + (AW+1)'(1);
      end
      if (enter_send) begin
        rd_idx_reg <= send_idx;
      end
      if (state_reg == ST_GAP) begin
        gap_reg <= gap_reg + 4'd1;
      end else begin
        gap_reg <= '0;
      end
      if ((state_reg == ST_LOAD) && bus.iWrValid && (count_reg == FULL_COUNT)) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Display-list storage: write port appends at the current count.
  always_ff @(posedge iClock) begin
    if (wr_fire) begin
      mem[count_reg[AW-1:0]] <= {bus.iWrX, bus.iWrY};
    end
  end

  // Registered read doubles as the X/Y output register; it only updates on
  // entry to SEND so the data stays stable through GAP and ARM.
  always_ff @(posedge iClock) begin
    if (iReset || bus.iClear) begin
      out_reg <= '0;
    end else if (enter_send) begin
      out_reg <= mem[send_idx];
    end
  end

  assign bus.oWrReady   = (state_reg == ST_LOAD) && (count_reg < FULL_COUNT);
  assign bus.oEnable    = (state_reg == ST_SEND) || (state_reg == ST_GAP);
  assign bus.oVertex    = (state_reg == ST_SEND);
  assign bus.oBusy      = (state_reg != ST_LOAD);
  assign bus.oOverflow  = overflow_reg;
  assign bus.o_ieee754X = out_reg[31:16];
  assign bus.o_ieee754Y = out_reg[15:0];

endmodule
